// File: rtl/rnl_neuron_if.sv
// Bundle between the delay-unit bank and the RNL neuron body.
// The master drives synaptic pulses and threshold; the slave (neuron) drives the spike outputs.
interface rnl_neuron_if #(
  parameter int unsigned NUM_INPUTS        = 8,
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16
);
  localparam int unsigned POT_W = $clog2(NUM_INPUTS * GAMMA_CYCLE_WIDTH + 1);
  localparam int unsigned CW    = $clog2(GAMMA_CYCLE_WIDTH);

  logic [NUM_INPUTS-1:0] in_spikes;
  logic [POT_W-1:0]      threshold;
  logic                  out;
  logic [CW-1:0]         spike_time;
  logic                  fired;
  logic [CW-1:0]         gamma_cnt;

  modport master (
    output in_spikes, threshold,
    input  out, spike_time, fired, gamma_cnt
  );

  modport slave (
    input  in_spikes, threshold,
    output out, spike_time, fired, gamma_cnt
  );
endinterface

// File: rtl/rnl_neuron.sv
// Ramp-no-leak neuron body: every rising input edge opens a unit ramp on the potential,
// and the neuron emits one fixed-width pulse per gamma cycle when the potential reaches threshold.
module rnl_neuron #(
  parameter int unsigned NUM_INPUTS        = 8,
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 4
) (
  input  logic         aclk,
  input  logic         grst,
  rnl_neuron_if.slave  bus
);
  localparam int unsigned POT_W = $clog2(NUM_INPUTS * GAMMA_CYCLE_WIDTH + 1);
  localparam int unsigned CW    = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int unsigned PCW   = $clog2(PULSE_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic {IDLE, PULSE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         gamma_cnt_q, gamma_cnt_d;
  logic [POT_W-1:0]      pot_q, pot_d;
  logic [NUM_INPUTS-1:0] ramp_q, ramp_d;
  logic [NUM_INPUTS-1:0] in_prev_q, in_prev_d;
  logic [PCW-1:0]        pcnt_q, pcnt_d;
  logic                  out_q, out_d;
  logic                  fired_q, fired_d;
  logic [CW-1:0]         spike_time_q, spike_time_d;

  logic                  wrap;
  logic                  fire;
  logic [NUM_INPUTS-1:0] rise;
  logic [NUM_INPUTS-1:0] act;
  logic [POT_W-1:0]      pot_next;

  // State register; grst overrides everything, including an active pulse.
  always_ff @(posedge aclk) begin
    if (grst) begin
      state_q      <= IDLE;
      gamma_cnt_q  <= '0;
      pot_q        <= '0;
      ramp_q       <= '0;
      in_prev_q    <= '0;
      pcnt_q       <= '0;
      out_q        <= 1'b0;
      fired_q      <= 1'b0;
      spike_time_q <= '0;
    end else begin
      state_q      <= state_d;
      gamma_cnt_q  <= gamma_cnt_d;
      pot_q        <= pot_d;
      ramp_q       <= ramp_d;
      in_prev_q    <= in_prev_d;
      pcnt_q       <= pcnt_d;
      out_q        <= out_d;
      fired_q      <= fired_d;
      spike_time_q <= spike_time_d;
    end
  end

  // Ramp accumulation, firing decision and pulse sequencing.
  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    fired_d      = fired_q;
    spike_time_d = spike_time_q;
    wrap         = (gamma_cnt_q == LAST_CNT);
    gamma_cnt_d  = gamma_cnt_q + CW'(1);
    rise         = bus.in_spikes & ~in_prev_q;
    act          = ramp_q | rise;
    in_prev_d    = bus.in_spikes;
    ramp_d       = act;

    pot_next = pot_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      pot_next = pot_next + POT_W'(act[i]);
    end
    pot_d = pot_next;

    // The last gamma index cannot fire: its pulse would be truncated to nothing.
    fire = !fired_q && (pot_next >= bus.threshold) && !wrap;
    if (fire) begin
      fired_d      = 1'b1;
      spike_time_d = gamma_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = PULSE;
          pcnt_d  = PCW'(PULSE_WIDTH - 1);
        end
      end
      PULSE: begin
        if (pcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          pcnt_d = pcnt_q - PCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (wrap) begin
      pot_d   = '0;
      ramp_d  = '0;
      fired_d = 1'b0;
      state_d = IDLE;
    end

    out_d = (state_d == PULSE);
  end

  assign bus.out        = out_q;
  assign bus.fired      = fired_q;
  assign bus.spike_time = spike_time_q;
  assign bus.gamma_cnt  = gamma_cnt_q;
endmodule

// File: tb/tb_rnl_neuron.sv
// Self-checking bench for rnl_neuron: directed scenarios plus random traffic,
// all compared cycle by cycle against a ramp-start-time reference model.
module tb_rnl_neuron;
  localparam int unsigned N     = 8;
  localparam int unsigned G     = 16;
  localparam int unsigned P     = 4;
  localparam int unsigned POT_W = $clog2(N * G + 1);
  localparam int unsigned CW    = $clog2(G);

  logic aclk = 1'b0;
  logic grst = 1'b0;
  always #5 aclk = ~aclk;

  rnl_neuron_if #(.NUM_INPUTS(N), .GAMMA_CYCLE_WIDTH(G)) bus ();

  rnl_neuron #(.NUM_INPUTS(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(P)) dut (
    .aclk (aclk),
    .grst (grst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each input remembers the gamma index its ramp started at.
  int   m_cnt;
  int   m_start [N];
  logic m_prev  [N];
  logic m_fired;
  int   m_spike;
  int   m_fire_k;
  int   m_pot;
  logic m_out;

  task automatic model_edge();
    int  k;
    int  potn;
    logic fire;
    if (grst) begin
      m_cnt = 0; m_fired = 1'b0; m_spike = 0; m_fire_k = -100; m_pot = 0;
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 1'b0; m_start[i] = -1;
      end
    end else begin
      k = m_cnt;
      potn = 0;
      for (int i = 0; i < N; i++) begin
        if (bus.in_spikes[i] && !m_prev[i] && m_start[i] < 0) m_start[i] = k;
        if (m_start[i] >= 0) potn += k - m_start[i] + 1;
        m_prev[i] = bus.in_spikes[i];
      end
      fire = !m_fired && (potn >= int'(bus.threshold)) && (k != G - 1);
      if (fire) begin
        m_fired = 1'b1; m_spike = k; m_fire_k = k;
      end
      m_pot = potn;
      if (k == G - 1) begin
        for (int i = 0; i < N; i++) m_start[i] = -1;
        m_fired = 1'b0; m_fire_k = -100; m_pot = 0;
      end
      m_cnt = (k + 1) % G;
    end
    m_out = (m_fire_k >= 0) && (m_cnt > m_fire_k) && (m_cnt <= m_fire_k + P);
  endtask

  function automatic logic [2*CW+1:0] exp_vec();
    return {m_out, m_fired, CW'(m_spike), CW'(m_cnt)};
  endfunction

  function automatic logic [2*CW+1:0] act_vec();
    return {bus.out, bus.fired, bus.spike_time, bus.gamma_cnt};
  endfunction

  task automatic step();
    @(posedge aclk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    grst = 1'b1;
    bus.in_spikes = '0;
    step();
    grst = 1'b0;
  endtask

  task automatic test_reset();
    bus.threshold = POT_W'(1);
    do_reset();
    checks++;
    if (act_vec() !== '0 || dut.pot_q !== '0) begin
      errors++;
      $display("FAIL reset actual=%h pot=%0d required=0 pot=0", act_vec(), dut.pot_q);
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model actual=%h required=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    int first_cnt = -1;
    int out_cycles = 0;
    do_reset();
    bus.threshold = POT_W'(1);
    for (int c = 0; c < 20; c++) begin
      bus.in_spikes = {7'b0, (c >= 3 && c < 9)};
      step();
      checks++;
      if (act_vec() !== exp_vec() || dut.pot_q !== POT_W'(m_pot)) begin
        errors++;
        $display("FAIL single c=%0d actual=%h pot=%0d required=%h pot=%0d",
                 c, act_vec(), dut.pot_q, exp_vec(), m_pot);
      end
      if (bus.out) begin
        out_cycles++;
        if (first_cnt < 0) first_cnt = int'(bus.gamma_cnt);
      end
    end
    checks++;
    if (first_cnt != 4 || out_cycles != 4 || bus.spike_time !== CW'(3)) begin
      errors++;
      $display("FAIL single_shape actual first=%0d len=%0d st=%0d required first=4 len=4 st=3",
               first_cnt, out_cycles, bus.spike_time);
    end
  endtask

  task automatic test_staggered();
    int first_cnt = -1;
    int out_cycles = 0;
    do_reset();
    bus.threshold = POT_W'(5);
    for (int c = 0; c < 20; c++) begin
      bus.in_spikes = {6'b0, (c >= 4), (c >= 2)};
      step();
      checks++;
      if (act_vec() !== exp_vec() || dut.pot_q !== POT_W'(m_pot)) begin
        errors++;
        $display("FAIL staggered c=%0d actual=%h pot=%0d required=%h pot=%0d",
                 c, act_vec(), dut.pot_q, exp_vec(), m_pot);
      end
      if (bus.out) begin
        out_cycles++;
        if (first_cnt < 0) first_cnt = int'(bus.gamma_cnt);
      end
    end
    checks++;
    if (first_cnt != 6 || out_cycles != 4 || bus.spike_time !== CW'(5)) begin
      errors++;
      $display("FAIL staggered_shape actual first=%0d len=%0d st=%0d required first=6 len=4 st=5",
               first_cnt, out_cycles, bus.spike_time);
    end
  endtask

  task automatic test_no_refire();
    int out_cycles = 0;
    do_reset();
    bus.threshold = POT_W'(10);
    for (int c = 0; c < 16; c++) begin
      bus.in_spikes = {5'b0, (c >= 9), (c >= 2), (c >= 2)};
      step();
      checks++;
      if (act_vec() !== exp_vec() || dut.pot_q !== POT_W'(m_pot)) begin
        errors++;
        $display("FAIL no_refire c=%0d actual=%h pot=%0d required=%h pot=%0d",
                 c, act_vec(), dut.pot_q, exp_vec(), m_pot);
      end
      if (bus.out) out_cycles++;
    end
    checks++;
    if (out_cycles != 4 || bus.spike_time !== CW'(6)) begin
      errors++;
      $display("FAIL no_refire_shape actual len=%0d st=%0d required len=4 st=6",
               out_cycles, bus.spike_time);
    end
  endtask

  task automatic test_boundaries();
    int out_cycles = 0;
    int fired_cycles = 0;
    int out2 = 0;
    do_reset();
    bus.threshold = POT_W'(1);
    for (int c = 0; c < 18; c++) begin
      bus.in_spikes = {7'b0, (c == 13)};
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL edge13 c=%0d actual=%h required=%h", c, act_vec(), exp_vec());
      end
      if (bus.out) out_cycles++;
    end
    checks++;
    if (out_cycles != 2) begin
      errors++;
      $display("FAIL edge13_len actual=%0d required=2", out_cycles);
    end
    do_reset();
    for (int c = 0; c < 20; c++) begin
      bus.in_spikes = {7'b0, (c >= 15)};
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL edge15 c=%0d actual=%h required=%h", c, act_vec(), exp_vec());
      end
      if (bus.fired || bus.out) fired_cycles++;
    end
    checks++;
    if (fired_cycles != 0) begin
      errors++;
      $display("FAIL edge15_fire actual=%0d required=0", fired_cycles);
    end
    do_reset();
    for (int c = 0; c < 32; c++) begin
      bus.threshold = (c < 16) ? POT_W'(1) : POT_W'(100);
      bus.in_spikes = {7'b0, ((c >= 3 && c < 6) || c >= 20)};
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL no_reach c=%0d actual=%h required=%h", c, act_vec(), exp_vec());
      end
      if (c >= 16 && bus.out) out2++;
    end
    checks++;
    if (out2 != 0 || bus.spike_time !== CW'(3)) begin
      errors++;
      $display("FAIL no_reach_hold actual out=%0d st=%0d required out=0 st=3", out2, bus.spike_time);
    end
  endtask

  task automatic test_cross_wrap();
    int out_cycles = 0;
    int fires = 0;
    logic prev_fired = 1'b0;
    do_reset();
    bus.threshold = POT_W'(1);
    for (int c = 0; c < 32; c++) begin
      bus.in_spikes = {7'b0, (c >= 14 && c <= 19)};
      step();
      checks++;
      if (act_vec() !== exp_vec() || dut.pot_q !== POT_W'(m_pot)) begin
        errors++;
        $display("FAIL cross_wrap c=%0d actual=%h pot=%0d required=%h pot=%0d",
                 c, act_vec(), dut.pot_q, exp_vec(), m_pot);
      end
      if (bus.out) out_cycles++;
      if (bus.fired && !prev_fired) fires++;
      prev_fired = bus.fired;
    end
    checks++;
    if (fires != 1 || out_cycles != 1 || bus.spike_time !== CW'(14)) begin
      errors++;
      $display("FAIL cross_wrap_once actual fires=%0d len=%0d st=%0d required fires=1 len=1 st=14",
               fires, out_cycles, bus.spike_time);
    end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    bus.threshold = POT_W'(1);
    for (int c = 0; c < 30; c++) begin
      grst = (c == 5);
      bus.in_spikes = {7'b0, (c >= 3)};
      step();
      checks++;
      if (act_vec() !== exp_vec() || dut.pot_q !== POT_W'(m_pot)) begin
        errors++;
        $display("FAIL reset_mid c=%0d actual=%h pot=%0d required=%h pot=%0d",
                 c, act_vec(), dut.pot_q, exp_vec(), m_pot);
      end
      if (c == 5) begin
        checks++;
        if (act_vec() !== '0 || dut.pot_q !== '0) begin
          errors++;
          $display("FAIL reset_mid_clear actual=%h pot=%0d required=0 pot=0", act_vec(), dut.pot_q);
        end
      end
    end
    grst = 1'b0;
  endtask

  task automatic test_threshold_zero();
    int pulses = 0;
    logic prev_out = 1'b0;
    do_reset();
    bus.threshold = '0;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL thr0 c=%0d actual=%h required=%h", c, act_vec(), exp_vec());
      end
      if (bus.out && !prev_out) pulses++;
      prev_out = bus.out;
    end
    checks++;
    if (pulses != 3 || bus.spike_time !== CW'(0)) begin
      errors++;
      $display("FAIL thr0_count actual=%0d st=%0d required=3 st=0", pulses, bus.spike_time);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      grst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 31) == 0) bus.threshold = POT_W'($urandom_range(0, 60));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) bus.in_spikes[i] = ~bus.in_spikes[i];
      end
      step();
      checks++;
      if (act_vec() !== exp_vec() || dut.pot_q !== POT_W'(m_pot)) begin
        errors++;
        $display("FAIL random c=%0d actual=%h pot=%0d required=%h pot=%0d",
                 c, act_vec(), dut.pot_q, exp_vec(), m_pot);
      end
    end
    grst = 1'b0;
  endtask

  initial begin
    bus.in_spikes = '0;
    bus.threshold = '0;
    m_cnt = 0; m_fired = 1'b0; m_spike = 0; m_fire_k = -100; m_pot = 0; m_out = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_start[i] = -1; m_prev[i] = 1'b0;
    end
    @(negedge aclk);
    test_reset();
    test_single();
    test_staggered();
    test_no_refire();
    test_boundaries();
    test_cross_wrap();
    test_reset_mid_pulse();
    test_threshold_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rnl_neuron.md
# rnl_neuron

Ramp-no-leak (RNL) neuron body for the temporal neural network datapath. It sits directly downstream of a bank of `delay` units, one per synapse; each delayed pulse opens a unit ramp on the body potential. The neuron fires a single output pulse in the first cycle the potential reaches `threshold`, at most once per gamma cycle. The gamma cycle is tracked by an internal counter aligned to `grst`, and the output pulse has the same shape as the pulses the `delay` units consume.

## Interface
- `NUM_INPUTS`, 8, number of synaptic inputs, one per upstream `delay` unit.
- `GAMMA_CYCLE_WIDTH`, 16, length of one gamma cycle in `aclk` cycles (power of 2).
- `PULSE_WIDTH`, 4, output pulse length in cycles (≥1, < `GAMMA_CYCLE_WIDTH`).
- Derived `POT_W` = $clog2(NUM_INPUTS*GAMMA_CYCLE_WIDTH+1).

Ports:
- `aclk`  in  1  the single clock; all state changes on its rising edge.
- `grst`  in  1  reset, synchronous and active-high; it also realigns the gamma counter.
- `in_spikes`  in  NUM_INPUTS  delayed pulses from the upstream `delay` units; only rising edges are significant.
- `threshold`  in  POT_W  firing threshold; quasi-static; sampled every cycle.
- `out`  out  1  output spike pulse.
- `spike_time`  out  $clog2(GAMMA_CYCLE_WIDTH)  gamma-cycle index at which the neuron fired.
- `fired`  out  1  high from the firing edge until the end of the gamma cycle.
- `gamma_cnt`  out  $clog2(GAMMA_CYCLE_WIDTH)  current position in the gamma cycle.

## Operation
- Reset (`grst`=1 at an edge): `gamma_cnt`, potential, ramp flags, `in_prev`, pulse counter, `out`, `fired` and `spike_time` all become 0. `grst` has priority over every other event, including mid-pulse and mid-gamma.
- Gamma counter: increments each cycle after reset and wraps from GAMMA_CYCLE_WIDTH-1 to 0.
- Edge detection, per input:
  - `edge[i]` = `in_spikes[i]` & ~`in_prev[i]`.
  - `in_prev` is registered every cycle and is not cleared at the gamma wrap.
  - A pulse that continues across the wrap therefore produces no new edge.
- Ramps:
  - `act` = `ramp` | `edge`.
  - `ramp` <= `act`.
  - `pot_next` = `pot` + popcount(`act`), registered into `pot`.
  - The same-cycle edge counts immediately.
  - An input whose edge is first sampled at `gamma_cnt`=k contributes GAMMA_CYCLE_WIDTH-k in total.
  - `pot` cannot overflow `POT_W`; no saturation logic is needed.
  - A second edge on an already ramping input has no effect.
- Firing:
  - Condition: !`fired` & (`pot_next` >= `threshold`) & (`gamma_cnt` != GAMMA_CYCLE_WIDTH-1).
  - On the firing edge: `fired`<=1, `spike_time`<=`gamma_cnt`, `out`<=1, pulse counter loaded.
  - Firing at the last gamma index is suppressed: no pulse and `fired` stays 0.
- Pulse FSM, states IDLE and PULSE:
  - IDLE→PULSE on fire.
  - PULSE lasts PULSE_WIDTH cycles, then IDLE.
  - PULSE is forced to IDLE (`out`=0) at the gamma wrap, which truncates the pulse.
- Gamma wrap (edge where `gamma_cnt`=GAMMA_CYCLE_WIDTH-1):
  - Cleared to 0: `pot`, `ramp`, `fired`, `out`.
  - `spike_time` holds its value until the next fire or reset.
- `threshold`=0: fires at `gamma_cnt`=0 of every gamma cycle.

## Timing
- Latency: an input edge sampled at edge t (`gamma_cnt`=k) can raise `out` in the cycle after t, i.e. while `gamma_cnt`=k+1.
- `out` stays high for min(PULSE_WIDTH, GAMMA_CYCLE_WIDTH-1-k_fire) cycles.
- `spike_time` and `fired` become valid in the same cycle `out` rises.
- Simultaneous edges on several inputs in one cycle all count in that cycle.
- A wrap coinciding with an input edge: the edge is counted in the old gamma cycle (contributes 1). Its ramp is then cleared and it does not carry into the next gamma cycle.

## Test plan
Parameters for all scenarios: NUM_INPUTS=8, GAMMA=16, PULSE=4.
- Single input: `threshold`=1, `in_spikes[0]` edge sampled at `gamma_cnt`=3 → `out` high at `gamma_cnt` 4–7, `spike_time`=3, `fired`=1 until the wrap, `pot` cleared at `gamma_cnt`=0.
- Staggered ramps: `threshold`=5, edges on in[0] at cnt 2 and in[1] at cnt 4 → `pot` runs 1,2,4,6; fire at cnt 5; `out` high cnt 6–9; `spike_time`=5.
- Simultaneous edges plus no refire: `threshold`=10, in[0] and in[1] at cnt 2 → fire at cnt 6 (`pot`=10); a later edge on in[2] produces no second pulse in the same gamma cycle.
- Boundaries:
  - Edge at cnt 13, `threshold`=1 → `out` high at cnt 14–15 only, low at 0.
  - Edge at cnt 15 → no pulse, `fired`=0.
  - Threshold never reached → `out` stays 0 and `spike_time` holds its previous value.
- Cross-wrap pulse: in[0] high from cnt 14 through cnt 3 of the next gamma cycle → at most one fire, in the first gamma cycle; no edge and no fire in the second.
- Reset mid-pulse: `grst` asserted at cnt 5 during PULSE → next cycle `out`=0, `fired`=0, `spike_time`=0, `pot`=0, `gamma_cnt`=0; normal operation resumes after deassertion.
